phase_sequencer: RTL
====================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255: bus-wait limit in cycles for imem/dmem handshakes; 0 disables timeout.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 run  input  1  level; 1 = free-run instructions, 0 = stop at next instruction boundary.
REQ-005 step_req  input  1  pulse; while halted, execute exactly one instruction.
REQ-006 imem_req  output  1  instruction fetch request, held until ack.
REQ-007 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 mem_op  input  1  from decoder: current instruction needs a data-memory access in commit.
REQ-010 dmem_req  output  1  data access request, held until ack.
REQ-011 dmem_ack  input  1  data access complete.
REQ-012 instr  output  32  latched instruction register feeding decoder.
REQ-013 phase_execute / phase_commit / phase_step  output  1 each  one-hot phase strobes to PC and register datapath.
REQ-014 en  output  1  datapath enable; high in every non-HALT, non-FAULT state.
REQ-015 halted  output  1  high in HALT.
REQ-016 fault  output  1  sticky bus-timeout flag.
REQ-017 instret  output  32  retired instruction count.

Function
REQ-018 FSM states SHALL be HALT, FETCH, EXECUTE, COMMIT, STEP, FAULT.
REQ-019 At most one of phase_execute, phase_commit, phase_step SHALL be high in any cycle; all three low in HALT, FETCH, FAULT.
REQ-020 HALT: if run=1 or step_req=1 -> FETCH next cycle; if both, run takes precedence (free-run); a step_req is recorded in an internal single_step flag.
REQ-021 FETCH: imem_req=1 from the first FETCH cycle until the cycle imem_ack=1 inclusive; on ack instr <= imem_rdata and -> EXECUTE.
REQ-022 imem_ack in the same cycle as FETCH entry SHALL be accepted (minimum fetch latency 1 cycle).
REQ-023 EXECUTE: exactly one cycle, phase_execute=1, -> COMMIT.
REQ-024 COMMIT: phase_commit=1 every cycle in state; if mem_op=0, exactly one cycle then -> STEP; if mem_op=1, dmem_req=1 until dmem_ack, -> STEP on the ack cycle.
REQ-025 mem_op SHALL be sampled every COMMIT cycle; decoder holds it stable because instr is stable outside FETCH.
REQ-026 STEP: exactly one cycle, phase_step=1, instret increments by 1 (32-bit wrap 0xFFFFFFFF -> 0).
REQ-027 STEP exit: if single_step flag set -> HALT and clear flag; else if run=1 -> FETCH; else -> HALT.
REQ-028 run deasserted mid-instruction SHALL NOT abort it; instruction completes through STEP, then HALT.
REQ-029 step_req outside HALT SHALL be ignored.
REQ-030 Minimum instruction latency 4 cycles (FETCH, EXECUTE, COMMIT, STEP) with same-cycle acks and mem_op=0.
REQ-031 Timeout counter clears on entry to FETCH and COMMIT and increments each waiting cycle; when TIMEOUT>0 and count reaches TIMEOUT without ack -> FAULT, request dropped.
REQ-032 FAULT: fault=1, en=0, all requests low; exit only by reset; run/step_req ignored.
REQ-033 instr SHALL change only on a FETCH cycle with imem_ack=1.

Reset
REQ-034 rstn=0 sampled at a clk edge: state=HALT, instr=0, instret=0, fault=0, single_step=0, timeout count=0, all requests and phases 0, en=0, halted=1.
REQ-035 Reset mid-handshake SHALL drop imem_req/dmem_req the cycle after the reset edge, no phase strobe issued.
REQ-036 Reset has priority over every other input in the same cycle.

Verification
REQ-037 Reset, run=1, imem_ack tied 1, mem_op=0, imem_rdata=0x00000013 -> instr=0x13, phase_step every 4th cycle, instret=3 after 12 cycles.
REQ-038 run=1, imem_ack delayed 3 cycles, mem_op=1, dmem_ack delayed 2 cycles -> imem_req high 4 cycles, phase_commit high 3 cycles, one phase_step, instret=1.
REQ-039 Halted, step_req pulse 1 cycle, acks immediate -> exactly one phase_execute/commit/step sequence, halted=1 again after 5 cycles, instret=1.
REQ-040 run dropped during COMMIT -> STEP still issued, then HALT; instret increments once.
REQ-041 TIMEOUT=4, imem_ack held 0 -> imem_req high 4 cycles, then fault=1, en=0; run toggles ignored; rstn=0 clears fault.
REQ-042 instret preloaded by running to 0xFFFFFFFF, one more instruction -> instret=0x00000000, no other effect.

Source files
------------

// File: rtl/phase_sequencer.sv
// phase_sequencer
// Instruction phase controller. Sequences each instruction through
// FETCH -> EXECUTE -> COMMIT -> STEP, either free-running (run=1) or one
// instruction at a time (step_req pulse while halted). Bus waits on the
// instruction and data ports are bounded by TIMEOUT; an expired wait parks
// the sequencer in a sticky FAULT state that only reset leaves.
//
// Handshake semantics: a request (imem_req / dmem_req) is held high from its
// first cycle up to and including the cycle its ack is seen; an ack in the
// first request cycle is accepted. Acks outside a request are ignored.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   run, step_req        free-run level / single-step pulse (honoured in HALT)
//   imem_req/ack/rdata   instruction fetch handshake and fetched word
//   mem_op               decoder: current instruction needs a data access
//   dmem_req/ack         data access handshake (COMMIT only)
//   instr                latched instruction register
//   phase_execute/commit/step  one-hot phase strobes
//   en, halted, fault    datapath enable, HALT indicator, sticky timeout flag
//   instret              retired instruction count (wraps)
module phase_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        run,
    input  logic        step_req,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        mem_op,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic [31:0] instr,
    output logic        phase_execute,
    output logic        phase_commit,
    output logic        phase_step,
    output logic        en,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_HALT    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXECUTE = 3'd2,
        S_COMMIT  = 3'd3,
        S_STEP    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    // Last wait-count value that may still see an ack before faulting.
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        single_step_q, single_step_d;

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instret_d     = instret_q;
        to_cnt_d      = to_cnt_q;
        single_step_d = single_step_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        phase_execute = 1'b0;
        phase_commit  = 1'b0;
        phase_step    = 1'b0;
        en            = 1'b0;
        halted        = 1'b0;
        fault         = 1'b0;

        case (state_q)
            S_HALT: begin
                halted = 1'b1;
                // run wins over step_req: free-run, no single-step recorded.
                if (run) begin
                    state_d       = S_FETCH;
                    to_cnt_d      = 32'd0;
                    single_step_d = 1'b0;
                end else if (step_req) begin
                    state_d       = S_FETCH;
                    to_cnt_d      = 32'd0;
                    single_step_d = 1'b1;
                end
            end
            S_FETCH: begin
                en       = 1'b1;
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXECUTE;
                end else if ((TIMEOUT > 0) && (to_cnt_q == TO_LAST)) begin
                    state_d = S_FAULT;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            S_EXECUTE: begin
                en            = 1'b1;
                phase_execute = 1'b1;
                state_d       = S_COMMIT;
                to_cnt_d      = 32'd0;
            end
            S_COMMIT: begin
                en           = 1'b1;
                phase_commit = 1'b1;
                if (!mem_op) begin
                    state_d = S_STEP;
                end else begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        state_d = S_STEP;
                    end else if ((TIMEOUT > 0) && (to_cnt_q == TO_LAST)) begin
                        state_d = S_FAULT;
                    end else begin
                        to_cnt_d = to_cnt_q + 32'd1;
                    end
                end
            end
            S_STEP: begin
                en         = 1'b1;
                phase_step = 1'b1;
                instret_d  = instret_q + 32'd1;
                if (single_step_q) begin
                    state_d       = S_HALT;
                    single_step_d = 1'b0;
                end else if (run) begin
                    state_d  = S_FETCH;
                    to_cnt_d = 32'd0;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_HALT;
            instr_q       <= 32'd0;
            instret_q     <= 32'd0;
            to_cnt_q      <= 32'd0;
            single_step_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instret_q     <= instret_d;
            to_cnt_q      <= to_cnt_d;
            single_step_q <= single_step_d;
        end
    end

    assign instr   = instr_q;
    assign instret = instret_q;

endmodule
